dmem_arbiter: RTL

Two-requester arbiter sharing the single data-memory port (dmem_top) between the core load/store path (port 0) and a debug/program-loader port (port 1).
- Sequences each access through a small FSM: issue, wait for memory read latency, return data.
- Grants fairly (round-robin) so the loader cannot starve the core, and vice versa.
- Sits between the datapath/loader and dmem_top; drives dmem_top we/re/addr/data/func3.

---
 rtl/dmem_arb_pkg.sv | 23 ++
 rtl/rr_arb2.sv | 38 +++
 rtl/dmem_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dmem_arb_pkg
// Purpose : Shared state encoding, port ids and counter sizing for dmem_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_LOAD = 1'b1;

    // Wide enough to count 0..MEM_LAT-1 for MEM_LAT up to 4.
    localparam int CNT_W = 2;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module  : rr_arb2
// Purpose : Two-input round-robin arbiter; pointer remembers the last winner.
// Revision: 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] gnt_o
);
    import dmem_arb_pkg::*;

    logic last_q;

    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = (last_q == PORT_LOAD) ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

    // Pointer moves when the winner is latched, so it names the winner from ISSUE on.
    always_ff @(posedge clk) begin
        if (!reset) begin
            last_q <= PORT_LOAD;
        end else if (advance_i && (req_i != 2'b00)) begin
            last_q <= gnt_o[1];
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : dmem_arbiter
// Purpose : Shares the dmem port between core (port 0) and loader (port 1).
// Revision: 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [2:0]        m0_func3,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic [2:0]        m1_func3,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [2:0]        mem_func3,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);
    import dmem_arb_pkg::*;

    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(MEM_LAT - 1);

    arb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        arb_gnt;
    logic              take_cmd;
    logic              sample_rd;
    logic              id_q;
    logic              cmd_we_q;
    logic              mem_we_q, mem_re_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [2:0]        mem_func3_q;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [2:0]        sel_func3;

    rr_arb2 u_rr (
        .clk       (clk),
        .reset     (reset),
        .req_i     ({m1_req, m0_req}),
        .advance_i (state_q == IDLE),
        .gnt_o     (arb_gnt)
    );

    assign take_cmd  = (state_q == IDLE) && (m0_req || m1_req);
    assign sample_rd = (state_q == WAIT) && (cnt_q == LAT_LAST);

    always_comb begin
        sel_we    = arb_gnt[1] ? m1_we    : m0_we;
        sel_addr  = arb_gnt[1] ? m1_addr  : m0_addr;
        sel_wdata = arb_gnt[1] ? m1_wdata : m0_wdata;
        sel_func3 = arb_gnt[1] ? m1_func3 : m0_func3;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE:  if (take_cmd) state_d = ISSUE;
            ISSUE: begin
                cnt_d   = '0;
                state_d = cmd_we_q ? IDLE : WAIT;
            end
            WAIT: begin
                if (cnt_q == LAT_LAST) state_d = RESP;
                else                   cnt_d   = cnt_q + CNT_W'(1);
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            id_q        <= PORT_CORE;
            cmd_we_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_func3_q <= '0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mem_we_q <= 1'b0;
            mem_re_q <= 1'b0;
            // Strobes are set only for the single ISSUE cycle that follows.
            if (take_cmd) begin
                id_q        <= arb_gnt[1];
                cmd_we_q    <= sel_we;
                mem_we_q    <= sel_we;
                mem_re_q    <= ~sel_we;
                mem_addr_q  <= sel_addr;
                mem_wdata_q <= sel_wdata;
                mem_func3_q <= sel_func3;
            end
            if (sample_rd) begin
                if (id_q == PORT_LOAD) rdata1_q <= mem_rdata;
                else                   rdata0_q <= mem_rdata;
            end
        end
    end

    assign m0_gnt    = (state_q == ISSUE) && (id_q == PORT_CORE);
    assign m1_gnt    = (state_q == ISSUE) && (id_q == PORT_LOAD);
    assign m0_rvalid = (state_q == RESP)  && (id_q == PORT_CORE);
    assign m1_rvalid = (state_q == RESP)  && (id_q == PORT_LOAD);
    assign m0_rdata  = rdata0_q;
    assign m1_rdata  = rdata1_q;
    assign mem_we    = mem_we_q;
    assign mem_re    = mem_re_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_func3 = mem_func3_q;
    assign busy      = (state_q != IDLE);

endmodule
`default_nettype wire
